// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_pkg
// Brief    : Shared SECDED helpers: Hamming parity count, codeword width and
//            the controller state encoding.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package ecc_pkg;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_DEC  = 2'd2;
    localparam logic [1:0] c_ST_WB   = 2'd3;

    // Smallest r with 2**r >= dw + r + 1. Seven steps cover data widths up to 64.
    function automatic int ecc_p(input int dw);
        int r;
        r = 1;
        for (int i = 0; i < 7; i++) begin
            if ((1 << r) < (dw + r + 1)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Hamming bits plus the overall parity bit
    function automatic int ecc_cw(input int dw);
        return dw + ecc_p(dw) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secded_codec.sv
`default_nettype none
// ============================================================================
// Module   : secded_codec
// Brief    : Combinational SECDED encoder and decoder. Codeword bit i-1 holds
//            Hamming position i; parity at powers of two, data ascending in
//            the remaining slots, MSB is the overall parity.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module secded_codec
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]         i_enc_data,
    output logic [ecc_cw(DATA_WIDTH)-1:0] o_enc_cw,
    input  logic [ecc_cw(DATA_WIDTH)-1:0] i_dec_cw,
    output logic [DATA_WIDTH-1:0]         o_dec_data,
    output logic                          o_dec_sbe,
    output logic                          o_dec_dbe,
    output logic [ecc_cw(DATA_WIDTH)-1:0] o_dec_cw_fixed
);

    localparam int c_P  = ecc_p(DATA_WIDTH);
    localparam int c_N  = DATA_WIDTH + c_P;

    logic [c_N-1:0] w_placed;      // data in its slots, zeros at parity slots
    logic [c_P-1:0] w_par;
    logic [c_N-1:0] w_enc_body;
    logic [c_P-1:0] w_syn;
    logic           w_pe;
    logic [c_N-1:0] w_flip;
    logic [c_N-1:0] w_fixed_body;

    // Position gp (1-based) carries data bit gp - floor(log2(gp)) - 2 when it
    // is not a power of two; floor(log2(gp)) + 1 equals $clog2(gp + 1).
    generate
        for (genvar gp = 1; gp <= c_N; gp++) begin : g_place
            if ((gp & (gp - 1)) == 0) begin : g_par_slot
                assign w_placed[gp-1] = 1'b0;
            end else begin : g_data_slot
                assign w_placed[gp-1]                    = i_enc_data[gp - $clog2(gp + 1) - 1];
                assign o_dec_data[gp - $clog2(gp + 1) - 1] = w_fixed_body[gp-1];
            end
        end
    endgenerate

    // Parity bit k covers every position whose index has bit k set
    always_comb begin
        w_par = '0;
        for (int k = 0; k < c_P; k++) begin
            for (int pos = 1; pos <= c_N; pos++) begin
                if (((pos >> k) & 1) == 1) begin
                    w_par[k] = w_par[k] ^ w_placed[pos-1];
                end
            end
        end
    end

    // Drop the parity bits into their power-of-two slots
    always_comb begin
        w_enc_body = w_placed;
        for (int k = 0; k < c_P; k++) begin
            w_enc_body[(1 << k) - 1] = w_par[k];
        end
    end

    assign o_enc_cw = {^w_enc_body, w_enc_body};

    // Syndrome: XOR of the positions of all set bits equals the error position
    always_comb begin
        w_syn = '0;
        for (int k = 0; k < c_P; k++) begin
            for (int pos = 1; pos <= c_N; pos++) begin
                if (((pos >> k) & 1) == 1) begin
                    w_syn[k] = w_syn[k] ^ i_dec_cw[pos-1];
                end
            end
        end
    end

    assign w_pe = ^i_dec_cw;

    // Flip the addressed position only when overall parity says one bit is bad
    always_comb begin
        w_flip = '0;
        if (w_pe) begin
            for (int pos = 1; pos <= c_N; pos++) begin
                if (int'(w_syn) == pos) begin
                    w_flip[pos-1] = 1'b1;
                end
            end
        end
    end

    assign w_fixed_body   = i_dec_cw[c_N-1:0] ^ w_flip;
    // Overall bit is recomputed, which also repairs an error in the MSB alone
    assign o_dec_cw_fixed = {^w_fixed_body, w_fixed_body};
    assign o_dec_sbe      = w_pe;
    assign o_dec_dbe      = !w_pe && (w_syn != '0);

endmodule
`default_nettype wire

// File: rtl/ecc_ram_secded_scrub.sv
`default_nettype none
// ============================================================================
// Module   : ecc_ram_secded_scrub
// Brief    : Single-port SECDED RAM with read correction, single-bit
//            writeback, background scrubbing, error injection and saturating
//            error counters behind a ready/valid request port.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module ecc_ram_secded_scrub
    import ecc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SCRUB_INTERVAL = 256,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    input  logic                          inj_en,
    input  logic [ecc_cw(DATA_WIDTH)-1:0] inj_mask,
    input  logic                          scrub_en,
    input  logic                          cnt_clr,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_sbe,
    output logic                          rsp_dbe,
    output logic [CNT_WIDTH-1:0]          sbe_count,
    output logic [CNT_WIDTH-1:0]          dbe_count,
    output logic [ADDR_WIDTH-1:0]         err_addr
);

    localparam int c_CW    = ecc_cw(DATA_WIDTH);
    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_TW    = $clog2(SCRUB_INTERVAL);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(SCRUB_INTERVAL - 1);

    logic [c_CW-1:0]       r_mem [c_DEPTH];
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_op_addr;
    logic                  r_op_scrub;
    logic [c_CW-1:0]       r_rd_cw;
    logic [c_CW-1:0]       r_wb_cw;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_sbe;
    logic                  r_rsp_dbe;
    logic [CNT_WIDTH-1:0]  r_sbe_cnt;
    logic [CNT_WIDTH-1:0]  r_dbe_cnt;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic [c_TW-1:0]       r_timer;
    logic                  r_scrub_pending;
    logic [ADDR_WIDTH-1:0] r_scrub_addr;

    logic                  w_user_write;
    logic                  w_user_read;
    logic                  w_scrub_launch;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [c_CW-1:0]       w_mem_wdata;
    logic [c_CW-1:0]       w_enc_cw;
    logic [DATA_WIDTH-1:0] w_dec_data;
    logic                  w_dec_sbe;
    logic                  w_dec_dbe;
    logic [c_CW-1:0]       w_dec_cw_fixed;
    logic                  w_in_dec;

    secded_codec #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_codec (
        .i_enc_data     (req_wdata),
        .o_enc_cw       (w_enc_cw),
        .i_dec_cw       (r_rd_cw),
        .o_dec_data     (w_dec_data),
        .o_dec_sbe      (w_dec_sbe),
        .o_dec_dbe      (w_dec_dbe),
        .o_dec_cw_fixed (w_dec_cw_fixed)
    );

    assign w_in_dec = (r_state == c_ST_DEC);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: reads walk RD -> DEC, then WB only when a correction is due
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_user_read || w_scrub_launch) w_state_next = c_ST_RD;
            c_ST_RD:   w_state_next = c_ST_DEC;
            c_ST_DEC:  w_state_next = w_dec_sbe ? c_ST_WB : c_ST_IDLE;
            c_ST_WB:   w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Handshake, scrub launch and the single array write port
    always_comb begin
        req_ready      = (r_state == c_ST_IDLE) && !rst;
        w_user_write   = req_ready && req_valid && req_we;
        w_user_read    = req_ready && req_valid && !req_we;
        // User traffic wins: a scrub only starts on a cycle with no request
        w_scrub_launch = req_ready && scrub_en && r_scrub_pending && !req_valid;
        w_mem_we       = 1'b0;
        w_mem_addr     = req_addr;
        w_mem_wdata    = w_enc_cw ^ (inj_en ? inj_mask : '0);
        if (w_user_write) begin
            w_mem_we = 1'b1;
        end else if ((r_state == c_ST_WB) && !rst) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_op_addr;
            w_mem_wdata = r_wb_cw;
        end
    end

    // Storage array and its registered read port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        if (r_state == c_ST_RD) begin
            r_rd_cw <= r_mem[r_op_addr];
        end
    end

    // Capture the operation in flight and the codeword to write back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_addr  <= '0;
            r_op_scrub <= 1'b0;
            r_wb_cw    <= '0;
        end else begin
            if (w_user_read) begin
                r_op_addr  <= req_addr;
                r_op_scrub <= 1'b0;
            end else if (w_scrub_launch) begin
                r_op_addr  <= r_scrub_addr;
                r_op_scrub <= 1'b1;
            end
            if (w_in_dec) begin
                r_wb_cw <= w_dec_cw_fixed;
            end
        end
    end

    // Read response: one-cycle pulse for user reads, payload held in between
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_sbe   <= 1'b0;
            r_rsp_dbe   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_in_dec && !r_op_scrub) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= w_dec_data;
                r_rsp_sbe   <= w_dec_sbe;
                r_rsp_dbe   <= w_dec_dbe;
            end
        end
    end

    // Saturating error counters and last-error address; clear beats an event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sbe_cnt  <= '0;
            r_dbe_cnt  <= '0;
            r_err_addr <= '0;
        end else begin
            if (cnt_clr) begin
                r_sbe_cnt <= '0;
                r_dbe_cnt <= '0;
            end else begin
                if (w_in_dec && w_dec_sbe && (r_sbe_cnt != '1)) begin
                    r_sbe_cnt <= r_sbe_cnt + 1'b1;
                end
                if (w_in_dec && w_dec_dbe && (r_dbe_cnt != '1)) begin
                    r_dbe_cnt <= r_dbe_cnt + 1'b1;
                end
            end
            if (w_in_dec && (w_dec_sbe || w_dec_dbe)) begin
                r_err_addr <= r_op_addr;
            end
        end
    end

    // Scrub timer advances only while enabled and idle; scrub address walks the array
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer         <= '0;
            r_scrub_pending <= 1'b0;
            r_scrub_addr    <= '0;
        end else begin
            if (w_scrub_launch) begin
                r_scrub_pending <= 1'b0;
            end
            if (scrub_en && (r_state == c_ST_IDLE)) begin
                if (r_timer == c_TIMER_LAST) begin
                    r_timer         <= '0;
                    r_scrub_pending <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
            if (w_in_dec && r_op_scrub) begin
                r_scrub_addr <= r_scrub_addr + 1'b1;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_sbe   = r_rsp_sbe;
    assign rsp_dbe   = r_rsp_dbe;
    assign sbe_count = r_sbe_cnt;
    assign dbe_count = r_dbe_cnt;
    assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ecc_ram_secded_scrub.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_ram_secded_scrub
// Brief    : Scoreboard bench for ecc_ram_secded_scrub (8-bit data, 16 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_ram_secded_scrub;

    localparam int ADDR_WIDTH     = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int SCRUB_INTERVAL = 4;
    localparam int CNT_WIDTH      = 8;
    localparam int CW             = 13;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  inj_en;
    logic [CW-1:0]         inj_mask;
    logic                  scrub_en;
    logic                  cnt_clr;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_sbe;
    logic                  rsp_dbe;
    logic [CNT_WIDTH-1:0]  sbe_count;
    logic [CNT_WIDTH-1:0]  dbe_count;
    logic [ADDR_WIDTH-1:0] err_addr;

    always #5 clk = ~clk;

    ecc_ram_secded_scrub #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .SCRUB_INTERVAL (SCRUB_INTERVAL),
        .CNT_WIDTH      (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .inj_en    (inj_en),
        .inj_mask  (inj_mask),
        .scrub_en  (scrub_en),
        .cnt_clr   (cnt_clr),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_sbe   (rsp_sbe),
        .rsp_dbe   (rsp_dbe),
        .sbe_count (sbe_count),
        .dbe_count (dbe_count),
        .err_addr  (err_addr)
    );

    typedef struct {
        logic [7:0] data;
        logic       sbe;
        logic       dbe;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] sh_data [16];
    logic [12:0] sh_mask [16];
    int         exp_sbe  = 0;
    int         exp_dbe  = 0;
    int         exp_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference behaviour: 0 flips clean, 1 flip corrected, 2 flips raw data back.
    // Data bit j lives at codeword bit cmap[j] (positions 3,5,6,7,9,10,11,12).
    function automatic exp_t model(input logic [7:0] d, input logic [12:0] m);
        exp_t e;
        int   cmap [8];
        int   n;
        logic [7:0] raw;
        cmap = '{2, 4, 5, 6, 8, 9, 10, 11};
        n    = $countones(m);
        raw  = d;
        for (int j = 0; j < 8; j++) raw[j] = d[j] ^ m[cmap[j]];
        e.sbe  = (n == 1);
        e.dbe  = (n == 2);
        e.data = (n == 2) ? raw : d;
        e.cyc  = 0;
        return e;
    endfunction

    // Response monitor: pops the scoreboard on every rsp_valid pulse
    always @(negedge clk) begin : mon
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rdata", rsp_rdata, e.data);
                check("rsp_sbe", rsp_sbe, e.sbe);
                check("rsp_dbe", rsp_dbe, e.dbe);
                check("latency", cyc, e.cyc);
                check("ready_in_wb", req_ready, !e.sbe);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_write(input int a, input logic [7:0] d, input logic [12:0] m);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(a); req_wdata = d;
        inj_en = (m != 13'd0); inj_mask = m;
        sh_data[a] = d; sh_mask[a] = m;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; inj_en = 1'b0; inj_mask = '0;
    endtask

    task automatic do_read(input int a);
        exp_t e;
        wait_ready();
        e = model(sh_data[a], sh_mask[a]);
        e.cyc = cyc + 3;
        sb_q.push_back(e);
        if (e.sbe) begin
            sh_mask[a] = 13'd0;
            if (exp_sbe < 255) exp_sbe++;
        end
        if (e.dbe && exp_dbe < 255) exp_dbe++;
        if (e.sbe || e.dbe) exp_err = a;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'(a);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check("rsp_timeout", sb_q.size(), 64'd0);
            sb_q.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_sbe_cnt"}, sbe_count, exp_sbe);
        check({tag, "_dbe_cnt"}, dbe_count, exp_dbe);
        check({tag, "_err_addr"}, err_addr, exp_err);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        exp_sbe = 0; exp_dbe = 0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        inj_en = 1'b0; inj_mask = '0; scrub_en = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_ready", req_ready, 64'd0);
        check_counts("rst");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 64'd1);

        for (int a = 0; a < 16; a++) do_write(a, 8'(a * 17), 13'd0);

        // Clean write/read
        do_write(3, 8'hA5, 13'd0);
        do_read(3); drain(); check_counts("t1");

        // Single data-bit error, corrected then written back
        do_write(5, 8'h3C, 13'h0004);
        do_read(5); drain(); check_counts("t2a");
        do_read(5); drain(); check_counts("t2b");

        // Double error, no writeback so it repeats
        do_write(7, 8'hFF, 13'h0006);
        do_read(7); drain(); check_counts("t3a");
        do_read(7); drain(); check_counts("t3b");

        // Overall parity bit alone
        do_write(1, 8'h81, 13'h1000);
        do_read(1); drain();
        do_read(1); drain(); check_counts("t4");

        // Codeword layout: double flips expose which data bits sit where
        do_write(9, 8'h00, 13'h0014);  do_read(9);
        do_write(10, 8'h00, 13'h0A00); do_read(10);
        do_write(11, 8'h5A, 13'h0001); do_read(11);
        do_write(12, 8'h80, 13'h0800); do_read(12);
        drain(); check_counts("layout");

        // Clear wins over a DBE event landing in the same cycle
        do_read(7);
        cnt_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 cnt_clr = 1'b0;
        exp_sbe = 0; exp_dbe = 0;
        drain(); check_counts("clr_wins");

        // DBE counter saturates at all-ones
        for (int i = 0; i < 260; i++) do_read(7);
        drain(); check_counts("saturate");
        pulse_clr();
        check_counts("cleared");

        // Background scrub repairs a single-bit error without a response
        do_write(7, 8'hFF, 13'd0);
        do_write(9, 8'h00, 13'd0);
        do_write(10, 8'h00, 13'd0);
        do_write(2, 8'h55, 13'h0010);
        pulse_clr();
        scrub_en = 1'b1;
        repeat (200) @(negedge clk);
        scrub_en = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        sh_mask[2] = 13'd0; exp_sbe = 1; exp_err = 2;
        check_counts("scrub");
        do_read(2); drain(); check_counts("scrub_reread");

        // Reset during DEC abandons the read: no response, no writeback
        do_write(5, 8'h3C, 13'h0004);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_rsp_valid", rsp_valid, 64'd0);
        exp_sbe = 0; exp_dbe = 0; exp_err = 0;
        check_counts("rst_mid");
        repeat (4) @(negedge clk);
        do_read(5); drain(); check_counts("rst_reread");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_ram_secded_scrub.md
Name: ecc_ram_secded_scrub

Overview:
Parametrised single-port SECDED-protected RAM, the next generation of the team's fixed 8-bit ECC RAM. It computes the Hamming width for any data width and applies the correction to read data. Single-bit errors are written back to the array, and an autonomous background scrubber sweeps all addresses. The block adds error injection, saturating error counters and a ready/valid request interface, and sits between a bus slave and the storage array.

Parameters:
ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, data bits, legal 4..64
SCRUB_INTERVAL, 256, idle-enabled cycles between scrub reads, >=2
CNT_WIDTH, 8, width of each error counter
P (localparam), derived, smallest r with 2**r >= DATA_WIDTH+r+1 (4 for 8-bit)
CW (localparam), DATA_WIDTH+P+1, codeword width (13 for 8-bit)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
inj_en  in  1  apply inj_mask on this write
inj_mask  in  CW  codeword bits to flip on write
scrub_en  in  1  enable background scrubber
cnt_clr  in  1  synchronous clear of both counters
rsp_valid  out  1  one-cycle read response pulse, no backpressure
rsp_rdata  out  DATA_WIDTH  corrected read data
rsp_sbe  out  1  single-bit error corrected
rsp_dbe  out  1  uncorrectable double-bit error
sbe_count  out  CNT_WIDTH  saturating count of SBE (user reads + scrub)
dbe_count  out  CNT_WIDTH  saturating count of DBE (user reads + scrub)
err_addr  out  ADDR_WIDTH  address of most recent SBE/DBE

Behaviour:
- Codeword: bit i-1 holds Hamming position i (1..DATA_WIDTH+P). Parity bits sit at power-of-two positions, data bits fill the remaining positions in ascending order, and bit CW-1 is the overall parity (XOR of all other bits).
- Decode: syndrome = XOR of the positions of set bits, equal to the error position. pe = overall XOR of all CW bits.
  - syndrome 0, pe 0: clean.
  - pe 1: SBE. If syndrome is nonzero, flip that position; if syndrome is 0, only the overall bit is in error and the data is good.
  - syndrome nonzero, pe 0: DBE. Return the raw data bits.
- FSM states IDLE, RD, DEC, WB. req_ready = (state==IDLE) and not rst.
- Write: accepted in IDLE at edge T. At T, mem[addr] <= encode(wdata) ^ (inj_en ? inj_mask : 0). The FSM stays in IDLE, giving back-to-back writes.
- Read: accepted at edge T, moving IDLE->RD. The array output is registered at T+1 (RD->DEC). At T+2, rsp_valid=1 with rdata/flags (DEC->IDLE, or DEC->WB on SBE).
- WB: at T+3, the corrected re-encoded codeword is written back and the FSM returns to IDLE. No writeback on DBE.
- Scrubber: the timer counts only while scrub_en=1 and the FSM is in IDLE; it holds otherwise.
  - At SCRUB_INTERVAL the timer sets scrub_pending and clears.
  - The scrub read launches from IDLE only when req_valid=0; user requests have priority. req_ready drops while the scrub is in flight.
  - A scrub read follows the same RD/DEC/WB path, but rsp_valid stays 0.
  - Counters and err_addr still update on a scrub read. scrub_addr increments after each scrub and wraps from depth-1 to 0.
- Counters: each increments by 1 per SBE/DBE event, saturates at all-ones and clears on cnt_clr. If cnt_clr and an event occur in the same cycle, the clear wins.
- Reset:
  - rsp_valid, rsp_rdata, rsp_sbe, rsp_dbe, both counters, err_addr, scrub timer, scrub_addr and scrub_pending all go to 0.
  - The FSM goes to IDLE. Array contents are not reset.
  - Reset mid-operation abandons the operation: no response and no writeback.
- rsp_rdata and the flags hold their values between pulses; consumers qualify them with rsp_valid.

Decomposition:
- Package ecc_pkg: function ecc_p(DATA_WIDTH) returning P, CW derivation, and FSM state enum constants.
- Sub-module secded_codec (combinational, parametrised by DATA_WIDTH): encode port plus decode port returning corrected data, sbe, dbe and the corrected codeword.
- The top level holds the array, FSM, scrubber and counters.

Test Plan:
1. Write 0xA5 @3, then read @3 accepted at T -> rsp_valid at T+2 with rdata 0xA5, sbe=0, dbe=0, counters 0.
2. Write 0x3C @5 with inj_mask=13'h0004 -> read gives 0x3C, sbe=1, sbe_count=1, err_addr=5, req_ready low at T+3 (WB). Re-read gives sbe=0.
3. Write 0xFF @7 with inj_mask=13'h0006 -> read gives dbe=1, dbe_count=1. Re-read gives dbe=1 again, dbe_count=2 (no writeback).
4. Write 0x81 @1 with inj_mask=13'h1000 (overall bit) -> read gives 0x81, sbe=1. Re-read is clean.
5. SCRUB_INTERVAL=4: single-bit inject @2, scrub_en=1 with idle bus for 100 cycles -> sbe_count=1, err_addr=2, no rsp_valid. Later read @2 is clean.
6. Assert rst in the DEC cycle of a read of the bad word from test 2 -> no rsp_valid, counters 0. Re-read still gives sbe=1 (no writeback happened).
